// File: rtl/audio_pkg.sv
// Shared audio-interface constants for the I2S capture (ADC) and playback (DAC)
// paths. Both ends derive their clocks and bit strobes from the same frame
// counter layout, so they stay in phase.
//   - AUDIO_DATA_W : default sample width
//   - FRAME_LEN    : system clocks per LRCK frame
//   - *_BIT        : counter bit driving each generated clock
//   - BIT_STB_PHASE: counter phase within an SCK period at which SDOUT is sampled
package audio_pkg;

  localparam int unsigned AUDIO_DATA_W = 24;

  localparam int unsigned FRAME_LEN = 1024;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN);

  localparam int unsigned MCLK_BIT = 1;
  localparam int unsigned SCK_BIT  = 3;
  localparam int unsigned LRCK_BIT = 9;

  // Slot index is the counter field between SCK and LRCK bits (32 slots per half).
  localparam int unsigned SLOT_LSB = SCK_BIT + 1;
  localparam int unsigned SLOT_W   = LRCK_BIT - SLOT_LSB;

  // Mid SCK-high; leaves room for the 2-flop synchroniser delay.
  localparam logic [SCK_BIT:0] BIT_STB_PHASE = 4'b1011;

  localparam logic [CNT_W-1:0] HALF_END_CNT  = CNT_W'(FRAME_LEN / 2 - 1);
  localparam logic [CNT_W-1:0] FRAME_END_CNT = CNT_W'(FRAME_LEN - 1);

  // LRCK level per channel.
  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

endpackage

// File: rtl/i2s_clkgen.sv
// Free-running I2S frame counter and clock generator.
// Ports:
//   clk_i, rst_i    : system clock, synchronous active-high reset
//   mclk_o          : clk/4 master clock (registered)
//   sck_o           : clk/16 bit clock (registered)
//   lrck_o          : clk/1024 word select, low = left (registered)
//   slot_o          : slot index 0..31 within the current half-frame
//   bit_stb_o       : one-cycle strobe at the SDOUT sampling phase of each slot
//   half_end_o      : high in the last cycle of the left half (count 511)
//   frame_end_o     : high in the last cycle of the frame (count 1023)
//   frame_start_o   : high in the first cycle of the frame (count 0)
// All outputs are registered and aligned with the internal count value.
module i2s_clkgen
  import audio_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              mclk_o,
  output logic              sck_o,
  output logic              lrck_o,
  output logic [SLOT_W-1:0] slot_o,
  output logic              bit_stb_o,
  output logic              half_end_o,
  output logic              frame_end_o,
  output logic              frame_start_o
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mclk_q, sck_q, lrck_q;
  logic [SLOT_W-1:0] slot_q;
  logic              bit_stb_q, half_end_q, frame_end_q, frame_start_q;

  // Counter wraps naturally at FRAME_LEN (power of two).
  assign cnt_d = cnt_q + CNT_W'(1);

  // Every output is decoded from the next count so it lines up with cnt_q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q         <= '0;
      mclk_q        <= 1'b0;
      sck_q         <= 1'b0;
      lrck_q        <= 1'b0;
      slot_q        <= '0;
      bit_stb_q     <= 1'b0;
      half_end_q    <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_start_q <= 1'b1;
    end else begin
      cnt_q         <= cnt_d;
      mclk_q        <= cnt_d[MCLK_BIT];
      sck_q         <= cnt_d[SCK_BIT];
      lrck_q        <= cnt_d[LRCK_BIT];
      slot_q        <= cnt_d[LRCK_BIT-1:SLOT_LSB];
      bit_stb_q     <= (cnt_d[SCK_BIT:0] == BIT_STB_PHASE);
      half_end_q    <= (cnt_d == HALF_END_CNT);
      frame_end_q   <= (cnt_d == FRAME_END_CNT);
      frame_start_q <= (cnt_d == '0);
    end
  end

  assign mclk_o        = mclk_q;
  assign sck_o         = sck_q;
  assign lrck_o        = lrck_q;
  assign slot_o        = slot_q;
  assign bit_stb_o     = bit_stb_q;
  assign half_end_o    = half_end_q;
  assign frame_end_o   = frame_end_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: rtl/i2s_receiver.sv
// Master-mode I2S receiver for the audio ADC. Generates MCLK/SCK/LRCK from the
// system clock, deserialises standard I2S data (one-bit delay, MSB first) into
// two's-complement left/right samples and pulses sample_valid once per frame.
// Optional level detector (build with LEVEL_DETECT_EN) pulses loud the cycle
// after a frame whose peak magnitude exceeds THRESH, then stays quiet for
// HOLD_FRAMES frames. Without the macro loud is constant 0.
// Ports:
//   clk, rst          : 100 MHz system clock, synchronous active-high reset
//   en                : capture enable (clocks run regardless)
//   adc_sdout         : serial data from ADC, asynchronous to clk
//   adc_mclk/sck/lrck : generated clocks (clk/4, clk/16, clk/1024; lrck low = left)
//   left/right_sample : signed samples, DATA_W bits
//   sample_valid      : one-cycle pulse, both samples updated
//   loud              : one-cycle pulse, level above THRESH
module i2s_receiver
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W      = AUDIO_DATA_W,
  parameter int unsigned THRESH      = 32'd1_000_000,
  parameter int unsigned HOLD_FRAMES = 32'd4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              adc_sdout,
  output logic              adc_mclk,
  output logic              adc_sck,
  output logic              adc_lrck,
  output logic [DATA_W-1:0] left_sample,
  output logic [DATA_W-1:0] right_sample,
  output logic              sample_valid,
  output logic              loud
);

  logic [SLOT_W-1:0] slot;
  logic              bit_stb, half_end, frame_end, frame_start;

  i2s_clkgen u_clkgen (
    .clk_i         (clk),
    .rst_i         (rst),
    .mclk_o        (adc_mclk),
    .sck_o         (adc_sck),
    .lrck_o        (adc_lrck),
    .slot_o        (slot),
    .bit_stb_o     (bit_stb),
    .half_end_o    (half_end),
    .frame_end_o   (frame_end),
    .frame_start_o (frame_start)
  );

  logic [1:0]        sync_q, sync_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] left_hold_q, left_hold_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] right_q, right_d;
  logic              valid_q, valid_d;
  logic              frame_ok_q, frame_ok_d;
  logic              in_word_c;

  // Slot 0 is the I2S one-bit delay; slots 1..DATA_W carry MSB..LSB.
  assign in_word_c = bit_stb && (slot != '0) && (32'(slot) <= DATA_W);

  // Capture datapath and frame qualification.
  always_comb begin
    sync_d      = {sync_q[0], adc_sdout};
    shreg_d     = shreg_q;
    left_hold_d = left_hold_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = 1'b0;
    frame_ok_d  = frame_ok_q;

    // A frame qualifies only if en is high from its first cycle to its last.
    if (!en) begin
      frame_ok_d = 1'b0;
    end else if (frame_start) begin
      frame_ok_d = 1'b1;
    end

    // Truncating cast drops the old MSB; works for any DATA_W including 1.
    if (in_word_c) begin
      shreg_d = DATA_W'({shreg_q, sync_q[1]});
    end

    if (half_end) begin
      left_hold_d = shreg_q;
    end

    if (frame_end && frame_ok_q && en) begin
      left_d  = left_hold_q;
      right_d = shreg_q;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      shreg_q     <= '0;
      left_hold_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      frame_ok_q  <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      shreg_q     <= shreg_d;
      left_hold_q <= left_hold_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      frame_ok_q  <= frame_ok_d;
    end
  end

  assign left_sample  = left_q;
  assign right_sample = right_q;
  assign sample_valid = valid_q;

`ifdef LEVEL_DETECT_EN
  localparam int unsigned HOLD_W = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam logic [DATA_W-1:0] MOST_NEG = DATA_W'(1) << (DATA_W - 1);

  // Magnitude with the most-negative code saturated to the most-positive one.
  function automatic logic [DATA_W-1:0] abs_sat(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    r = x;
    if (x == MOST_NEG) begin
      r = ~MOST_NEG;
    end else if (x[DATA_W-1]) begin
      r = ~x + DATA_W'(1);
    end
    return r;
  endfunction

  logic [DATA_W-1:0] mag_l_c, mag_r_c, mag_max_c;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              loud_q, loud_d;

  // Evaluated in the sample_valid cycle, so loud lands one cycle later.
  always_comb begin
    mag_l_c   = abs_sat(left_q);
    mag_r_c   = abs_sat(right_q);
    mag_max_c = (mag_l_c > mag_r_c) ? mag_l_c : mag_r_c;
    hold_d    = hold_q;
    loud_d    = 1'b0;
    if (valid_q) begin
      if ((32'(mag_max_c) > THRESH) && (hold_q == '0)) begin
        loud_d = 1'b1;
        hold_d = HOLD_W'(HOLD_FRAMES);
      end else if (hold_q != '0) begin
        hold_d = hold_q - HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      loud_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      loud_q <= loud_d;
    end
  end

  assign loud = loud_q;
`else
  // Detector not built; its parameters fold into a constant and loud stays low.
  localparam logic DETECT_CFG = ^{THRESH, HOLD_FRAMES};
  assign loud = DETECT_CFG & 1'b0;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
`timescale 1ns/1ps
module tb_i2s_receiver;

  localparam int unsigned DW = 24;
  localparam int unsigned TH = 1_000_000;
`ifdef LEVEL_DETECT_EN
  localparam int unsigned HOLD = 4;
  localparam bit          LD   = 1'b1;
`else
  localparam int unsigned HOLD = 4096;
  localparam bit          LD   = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          adc_sdout = 1'b0;
  logic          adc_mclk, adc_sck, adc_lrck;
  logic [DW-1:0] left_sample, right_sample;
  logic          sample_valid, loud;

  i2s_receiver #(
    .DATA_W      (DW),
    .THRESH      (TH),
    .HOLD_FRAMES (HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .adc_sdout    (adc_sdout),
    .adc_mclk     (adc_mclk),
    .adc_sck      (adc_sck),
    .adc_lrck     (adc_lrck),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .loud         (loud)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // ADC model: shifts on SCK falling edges, one-bit delay after each LRCK change.
  logic [DW-1:0] cur_l = '0, cur_r = '0, tx = '0;
  int            bitidx = 0;
  logic          sck_prev = 1'b0, lrck_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      bitidx    = 0;
      sck_prev  = 1'b0;
      lrck_prev = 1'b0;
      adc_sdout = 1'b0;
    end else begin
      if (sck_prev && !adc_sck) begin
        if (adc_lrck != lrck_prev) bitidx = 0;
        else bitidx++;
        lrck_prev = adc_lrck;
        if (bitidx == 1) tx = adc_lrck ? cur_r : cur_l;
        adc_sdout = (bitidx >= 1 && bitidx <= DW) ? tx[DW - bitidx] : 1'b0;
      end
      sck_prev = adc_sck;
    end
  end

  // Scoreboard
  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic          loud;
  } exp_t;

  exp_t q[$];
  logic loud_due = 1'b0;
  logic loud_exp_due = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (loud_due) begin
      check("loud_after_valid", 32'(loud), 32'(loud_exp_due));
      loud_due = 1'b0;
    end else if (loud === 1'b1) begin
      check("loud_unexpected", 32'(loud), 32'(0));
    end
    if (sample_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("valid_unexpected", 32'(sample_valid), 32'(0));
      end else begin
        e = q.pop_front();
        check("left_sample", 32'(left_sample), 32'(e.l));
        check("right_sample", 32'(right_sample), 32'(e.r));
        loud_due     = 1'b1;
        loud_exp_due = e.loud;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_no_valid(input int n, input string name);
    int seen;
    seen = 0;
    repeat (n) begin
      step();
      if (sample_valid !== 1'b0) seen++;
    end
    check(name, 32'(seen), 32'(0));
  endtask

  // Called at frame position 0; returns at frame position 0 of the next frame.
  task automatic run_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                           input bit vld, input bit ld);
    cur_l = l;
    cur_r = r;
    if (vld) q.push_back(exp_t'{l, r, ld});
    wait_no_valid(1023, "early_valid");
    step();
    check("valid_at_frame_end", 32'(sample_valid), 32'(vld));
  endtask

  initial begin
    int   nv, mr, sr, lr;
    logic pm, ps, pl;

    repeat (3) step();
    check("rst_left", 32'(left_sample), 32'(0));
    check("rst_right", 32'(right_sample), 32'(0));
    check("rst_valid", 32'(sample_valid), 32'(0));
    check("rst_loud", 32'(loud), 32'(0));
    check("rst_mclk", 32'(adc_mclk), 32'(0));
    check("rst_sck", 32'(adc_sck), 32'(0));
    check("rst_lrck", 32'(adc_lrck), 32'(0));

    // Capture disabled for 3 frames while the ADC sends non-zero data.
    cur_l = 24'h111111;
    cur_r = 24'h222222;
    rst = 1'b0;
    nv = 0; mr = 0; sr = 0; lr = 0;
    pm = adc_mclk; ps = adc_sck; pl = adc_lrck;
    for (int i = 0; i < 3072; i++) begin
      step();
      if (adc_mclk && !pm) mr++;
      if (adc_sck && !ps) sr++;
      if (adc_lrck && !pl) lr++;
      pm = adc_mclk; ps = adc_sck; pl = adc_lrck;
      if (sample_valid !== 1'b0) nv++;
    end
    check("mclk_rises", 32'(mr), 32'(768));
    check("sck_rises", 32'(sr), 32'(192));
    check("lrck_rises", 32'(lr), 32'(3));
    check("disabled_valids", 32'(nv), 32'(0));
    check("disabled_left", 32'(left_sample), 32'(0));
    check("disabled_right", 32'(right_sample), 32'(0));

    // Normal capture.
    en = 1'b1;
    run_frame(24'h123456, 24'hFEDCBA, 1'b1, LD);
    run_frame(24'h123456, 24'hFEDCBA, 1'b1, 1'b0);
    run_frame(24'h800000, 24'h7FFFFF, 1'b1, 1'b0);

    // en dropped at count 600 for 1024 cycles: two frames lose qualification.
    cur_l = 24'hA5A5A5;
    cur_r = 24'h5A5A5A;
    wait_no_valid(600, "endrop_pre");
    en = 1'b0;
    wait_no_valid(424, "endrop_frame1");
    check("endrop_left_held1", 32'(left_sample), 32'(24'h800000));
    check("endrop_right_held1", 32'(right_sample), 32'(24'h7FFFFF));
    wait_no_valid(600, "endrop_off");
    en = 1'b1;
    wait_no_valid(424, "endrop_frame2");
    check("endrop_left_held2", 32'(left_sample), 32'(24'h800000));
    check("endrop_right_held2", 32'(right_sample), 32'(24'h7FFFFF));
    run_frame(24'hA5A5A5, 24'h5A5A5A, 1'b1, 1'b0);

    // Reset at count 300 mid-frame.
    wait_no_valid(300, "pre_reset");
    rst = 1'b1;
    step();
    check("midrst_left", 32'(left_sample), 32'(0));
    check("midrst_right", 32'(right_sample), 32'(0));
    check("midrst_valid", 32'(sample_valid), 32'(0));
    check("midrst_loud", 32'(loud), 32'(0));
    check("midrst_mclk", 32'(adc_mclk), 32'(0));
    check("midrst_sck", 32'(adc_sck), 32'(0));
    check("midrst_lrck", 32'(adc_lrck), 32'(0));
    rst = 1'b0;
    // First valid exactly 1024 cycles after release; hold counter was cleared.
    run_frame(24'h654321, 24'h000001, 1'b1, LD);

    // Drain hold, then threshold boundary and hold window.
    repeat (4) run_frame(24'h000000, 24'h000000, 1'b1, 1'b0);
    run_frame(24'h0F4240, 24'h0F4240, 1'b1, 1'b0);
    run_frame(24'h0F4241, 24'h0F4240, 1'b1, LD);
    repeat (4) run_frame(24'h000000, 24'h000000, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_frame(24'h800000, 24'h000000, 1'b1, LD & ((i == 0) || (i == 5)));
    end

    repeat (3) step();
    check("queue_empty", 32'(q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
